// File: rtl/if_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : if_fetch_pkg
// Purpose : Shared definitions for the IF-stage fetch responder: the
//           instruction address bus width and the fetch FSM state encoding.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package if_fetch_pkg;

  // Width of the instruction address bus seen by the PC register.
  localparam int INST_ADDR_BUS = 64;

  // Fetch FSM states, explicitly encoded on two bits.
  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_REQ  = 2'd1,
    IF_WAIT = 2'd2,
    IF_HOLD = 2'd3
  } if_state_t;

endpackage : if_fetch_pkg
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module  : if_fetch
// Purpose : IF-stage instruction fetch responder. Samples the PC, issues one
//           single-beat read on the instruction bus, picks the 32-bit
//           instruction out of the 64-bit beat and presents it with
//           inst_valid until the PC register advances.
// Ports   :
//   clk, rst                      clock, asynchronous active-low reset
//   if_fetch_cur_inst_addr_i      current PC
//   if_fetch_stall_i              downstream cannot accept (dont_fetch)
//   if_fetch_flush_i              jump/branch/trap redirect
//   if_fetch_inst_valid_o         instruction available (HOLD only)
//   if_fetch_inst_o               fetched instruction
//   if_fetch_inst_addr_o          address of the fetched instruction
//   if_fetch_fault_o              bus error or misaligned PC
//   if_fetch_rd_req_o/_addr_o     bus read request / 8-byte aligned address
//   if_fetch_rd_gnt_i             request accepted
//   if_fetch_rd_rvalid_i/_data_i  read data valid / data
//   if_fetch_rd_err_i             bus error (qualified by rvalid)
//   if_fetch_rd_rready_o          ready for read data (WAIT only)
// Rev     : 1.0  initial release
// ============================================================================
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_BUS,
  parameter int BUS_DW = 64,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] if_fetch_cur_inst_addr_i,
  input  logic              if_fetch_stall_i,
  input  logic              if_fetch_flush_i,
  output logic              if_fetch_inst_valid_o,
  output logic [INST_W-1:0] if_fetch_inst_o,
  output logic [ADDR_W-1:0] if_fetch_inst_addr_o,
  output logic              if_fetch_fault_o,
  output logic              if_fetch_rd_req_o,
  output logic [ADDR_W-1:0] if_fetch_rd_addr_o,
  input  logic              if_fetch_rd_gnt_i,
  input  logic              if_fetch_rd_rvalid_i,
  input  logic [BUS_DW-1:0] if_fetch_rd_data_i,
  input  logic              if_fetch_rd_err_i,
  output logic              if_fetch_rd_rready_o
);

  if_state_t         r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [INST_W-1:0] r_inst;
  logic              r_fault;
  logic              r_drop;       // in-flight beat belongs to a flushed PC
  logic              r_inst_valid;
  logic              r_rd_req;
  logic              r_rready;

  logic              w_misaligned;
  logic [INST_W-1:0] w_sel_inst;

  // Instructions are 4-byte aligned; anything else faults without a bus read.
  assign w_misaligned = (r_addr[1:0] != 2'b00);

  // Bit 2 of the PC picks the upper or lower word of the 8-byte beat.
  assign w_sel_inst = r_addr[2] ? if_fetch_rd_data_i[2*INST_W-1:INST_W]
                                : if_fetch_rd_data_i[INST_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IF_IDLE;
      r_addr       <= '0;
      r_inst       <= '0;
      r_fault      <= 1'b0;
      r_drop       <= 1'b0;
      r_inst_valid <= 1'b0;
      r_rd_req     <= 1'b0;
      r_rready     <= 1'b0;
    end else begin
      case (r_state)
        IF_IDLE: begin
          // A flush here needs no action: the redirected PC is what we sample.
          r_addr   <= if_fetch_cur_inst_addr_i;
          r_rd_req <= (if_fetch_cur_inst_addr_i[1:0] == 2'b00);
          r_state  <= IF_REQ;
        end

        IF_REQ: begin
          if (w_misaligned) begin
            // No request was raised; a redirect makes the fault moot.
            if (if_fetch_flush_i) begin
              r_state <= IF_IDLE;
            end else begin
              r_inst       <= '0;
              r_fault      <= 1'b1;
              r_inst_valid <= 1'b1;
              r_state      <= IF_HOLD;
            end
          end else if (if_fetch_rd_gnt_i) begin
            // Accepted requests cannot be recalled; a concurrent flush only
            // marks the returning beat for discard.
            r_rd_req <= 1'b0;
            r_rready <= 1'b1;
            r_drop   <= if_fetch_flush_i;
            r_state  <= IF_WAIT;
          end else if (if_fetch_flush_i) begin
            r_rd_req <= 1'b0;
            r_state  <= IF_IDLE;
          end
        end

        IF_WAIT: begin
          if (if_fetch_rd_rvalid_i) begin
            r_rready <= 1'b0;
            r_drop   <= 1'b0;
            if (r_drop || if_fetch_flush_i) begin
              r_state <= IF_IDLE;
            end else begin
              r_inst       <= w_sel_inst;
              r_fault      <= if_fetch_rd_err_i;
              r_inst_valid <= 1'b1;
              r_state      <= IF_HOLD;
            end
          end else if (if_fetch_flush_i) begin
            r_drop <= 1'b1;
          end
        end

        IF_HOLD: begin
          // This edge is also the one on which the PC register advances.
          if (!if_fetch_stall_i || if_fetch_flush_i) begin
            r_inst       <= '0;
            r_fault      <= 1'b0;
            r_inst_valid <= 1'b0;
            r_state      <= IF_IDLE;
          end
        end

        default: r_state <= IF_IDLE;
      endcase
    end
  end

  assign if_fetch_inst_valid_o = r_inst_valid;
  assign if_fetch_inst_o       = r_inst;
  assign if_fetch_inst_addr_o  = r_addr;
  assign if_fetch_fault_o      = r_fault;
  assign if_fetch_rd_req_o     = r_rd_req;
  assign if_fetch_rd_addr_o    = {r_addr[ADDR_W-1:3], 3'b000};
  assign if_fetch_rd_rready_o  = r_rready;

endmodule : if_fetch
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
// Module  : tb_if_fetch
// Purpose : Self-checking bench for if_fetch. The bench plays the PC register
//           and the instruction bus; expected instructions come from a
//           transaction-level model (word select by PC arithmetic).
// Rev     : 1.0  initial release
// ============================================================================
module tb_if_fetch;

  localparam int ADDR_W = 64;
  localparam int BUS_DW = 64;
  localparam int INST_W = 32;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] r_cur_addr;
  logic              r_stall;
  logic              r_flush;
  logic              r_gnt;
  logic              r_rvalid;
  logic [BUS_DW-1:0] r_rdata;
  logic              r_rerr;

  logic              w_inst_valid;
  logic [INST_W-1:0] w_inst;
  logic [ADDR_W-1:0] w_inst_addr;
  logic              w_fault;
  logic              w_rd_req;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_rready;

  int n_tests = 0;
  int n_fail  = 0;

  if_fetch #(
    .ADDR_W(ADDR_W),
    .BUS_DW(BUS_DW),
    .INST_W(INST_W)
  ) u_dut (
    .clk                      (clk),
    .rst                      (rst),
    .if_fetch_cur_inst_addr_i (r_cur_addr),
    .if_fetch_stall_i         (r_stall),
    .if_fetch_flush_i         (r_flush),
    .if_fetch_inst_valid_o    (w_inst_valid),
    .if_fetch_inst_o          (w_inst),
    .if_fetch_inst_addr_o     (w_inst_addr),
    .if_fetch_fault_o         (w_fault),
    .if_fetch_rd_req_o        (w_rd_req),
    .if_fetch_rd_addr_o       (w_rd_addr),
    .if_fetch_rd_gnt_i        (r_gnt),
    .if_fetch_rd_rvalid_i     (r_rvalid),
    .if_fetch_rd_data_i       (r_rdata),
    .if_fetch_rd_err_i        (r_rerr),
    .if_fetch_rd_rready_o     (w_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: the PC's byte offset within the 8-byte beat selects the word.
  function automatic logic [31:0] ref_inst(input logic [63:0] pc, input logic [63:0] data);
    int unsigned word;
    logic [63:0] shifted;
    word    = int'((pc % 8) / 4);
    shifted = data >> (32 * word);
    return shifted[31:0];
  endfunction

  function automatic logic [63:0] ref_line(input logic [63:0] pc);
    return pc - (pc % 8);
  endfunction

  // Precondition: DUT is in REQ for pc. Postcondition: DUT back in IDLE.
  task automatic run_from_req(input logic [63:0] pc, input int gw, input int rw,
                              input logic [63:0] data, input logic err,
                              input int nstall, input string tag);
    logic [31:0] e_inst;
    logic        e_fault;
    if ((pc % 4) != 0) begin
      check({tag, ":mis_req"}, 64'(w_rd_req), 64'd0);
      tick();
      e_inst  = 32'd0;
      e_fault = 1'b1;
    end else begin
      for (int i = 0; i < gw; i++) begin
        check({tag, ":req_wait"}, 64'(w_rd_req), 64'd1);
        tick();
      end
      check({tag, ":req"}, 64'(w_rd_req), 64'd1);
      check({tag, ":rd_addr"}, w_rd_addr, ref_line(pc));
      check({tag, ":no_valid_req"}, 64'(w_inst_valid), 64'd0);
      r_gnt = 1'b1;
      tick();
      r_gnt = 1'b0;
      check({tag, ":rready"}, 64'(w_rready), 64'd1);
      check({tag, ":req_drop"}, 64'(w_rd_req), 64'd0);
      for (int i = 0; i < rw; i++) begin
        check({tag, ":no_valid_wait"}, 64'(w_inst_valid), 64'd0);
        tick();
      end
      r_rvalid = 1'b1;
      r_rdata  = data;
      r_rerr   = err;
      tick();
      r_rvalid = 1'b0;
      r_rerr   = 1'b0;
      r_rdata  = {$urandom, $urandom};
      e_inst   = ref_inst(pc, data);
      e_fault  = err;
    end
    check({tag, ":valid"}, 64'(w_inst_valid), 64'd1);
    check({tag, ":inst"}, 64'(w_inst), 64'(e_inst));
    check({tag, ":inst_addr"}, w_inst_addr, pc);
    check({tag, ":fault"}, 64'(w_fault), 64'(e_fault));
    check({tag, ":hold_req"}, 64'(w_rd_req), 64'd0);
    for (int i = 0; i < nstall; i++) begin
      tick();
      check({tag, ":stall_valid"}, 64'(w_inst_valid), 64'd1);
      check({tag, ":stall_inst"}, 64'(w_inst), 64'(e_inst));
    end
    r_stall = 1'b0;
    tick();
    r_stall = 1'b1;
    check({tag, ":valid_drop"}, 64'(w_inst_valid), 64'd0);
  endtask

  task automatic fetch(input logic [63:0] pc, input int gw, input int rw,
                       input logic [63:0] data, input logic err,
                       input int nstall, input string tag);
    r_cur_addr = pc;
    r_stall    = 1'b1;
    tick();
    run_from_req(pc, gw, rw, data, err, nstall, tag);
  endtask

  // Flush while the read is outstanding; the late beat must never surface.
  task automatic flush_wait(input logic [63:0] pc, input int pre, input int post,
                            input string tag);
    r_cur_addr = pc;
    tick();
    r_gnt = 1'b1;
    tick();
    r_gnt = 1'b0;
    for (int i = 0; i < pre; i++) tick();
    r_flush = 1'b1;
    tick();
    r_flush = 1'b0;
    check({tag, ":rready_after_flush"}, 64'(w_rready), 64'd1);
    for (int i = 0; i < post; i++) begin
      check({tag, ":no_valid_dropwait"}, 64'(w_inst_valid), 64'd0);
      tick();
    end
    r_rvalid = 1'b1;
    r_rdata  = {$urandom, $urandom};
    tick();
    r_rvalid = 1'b0;
    check({tag, ":dropped_valid"}, 64'(w_inst_valid), 64'd0);
    check({tag, ":dropped_rready"}, 64'(w_rready), 64'd0);
  endtask

  initial begin
    logic [63:0] pc;
    logic [63:0] data;
    int          mode;

    rst        = 1'b0;
    r_cur_addr = '0;
    r_stall    = 1'b1;
    r_flush    = 1'b0;
    r_gnt      = 1'b0;
    r_rvalid   = 1'b0;
    r_rdata    = '0;
    r_rerr     = 1'b0;
    tick();
    tick();
    check("rst_valid", 64'(w_inst_valid), 64'd0);
    check("rst_req", 64'(w_rd_req), 64'd0);
    check("rst_rready", 64'(w_rready), 64'd0);
    check("rst_inst", 64'(w_inst), 64'd0);
    check("rst_fault", 64'(w_fault), 64'd0);
    check("rst_inst_addr", w_inst_addr, 64'd0);
    check("rst_rd_addr", w_rd_addr, 64'd0);
    rst = 1'b1;

    // Basic fetches: lower word, upper word, stall held 5 cycles.
    fetch(64'h8000_0000, 0, 0, 64'h1111_2222_0000_0013, 1'b0, 0, "lo");
    fetch(64'h8000_0004, 0, 0, 64'h1111_2222_0000_0013, 1'b0, 5, "hi_stall");

    // Flush in WAIT, rvalid two cycles later, then the redirected PC.
    flush_wait(64'h8000_0008, 0, 1, "fl_wait");
    fetch(64'h8000_0100, 1, 2, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 0, "after_fl");

    // Bus error and misaligned PC.
    fetch(64'h8000_000C, 0, 0, 64'h0123_4567_89AB_CDEF, 1'b1, 0, "buserr");
    fetch(64'h8000_0002, 0, 0, 64'h0, 1'b0, 1, "misalign");

    // Flush in REQ before grant.
    r_cur_addr = 64'h8000_0010;
    tick();
    r_flush = 1'b1;
    tick();
    r_flush = 1'b0;
    check("fl_req_req", 64'(w_rd_req), 64'd0);
    check("fl_req_valid", 64'(w_inst_valid), 64'd0);

    // Flush together with grant: beat is dropped.
    r_cur_addr = 64'h8000_0018;
    tick();
    r_gnt   = 1'b1;
    r_flush = 1'b1;
    tick();
    r_gnt   = 1'b0;
    r_flush = 1'b0;
    check("fl_gnt_rready", 64'(w_rready), 64'd1);
    r_rvalid = 1'b1;
    tick();
    r_rvalid = 1'b0;
    check("fl_gnt_valid", 64'(w_inst_valid), 64'd0);

    // Flush together with rvalid in WAIT.
    r_cur_addr = 64'h8000_0020;
    tick();
    r_gnt = 1'b1;
    tick();
    r_gnt    = 1'b0;
    r_rvalid = 1'b1;
    r_flush  = 1'b1;
    tick();
    r_rvalid = 1'b0;
    r_flush  = 1'b0;
    check("fl_rv_valid", 64'(w_inst_valid), 64'd0);
    check("fl_rv_rready", 64'(w_rready), 64'd0);

    // Flush in HOLD while stalled releases the slot.
    r_cur_addr = 64'h8000_0028;
    r_stall    = 1'b1;
    tick();
    r_gnt = 1'b1;
    tick();
    r_gnt    = 1'b0;
    r_rvalid = 1'b1;
    tick();
    r_rvalid = 1'b0;
    check("fl_hold_pre", 64'(w_inst_valid), 64'd1);
    r_flush = 1'b1;
    tick();
    check("fl_hold_post", 64'(w_inst_valid), 64'd0);

    // Flush in IDLE has no effect: the presented PC is still sampled.
    r_cur_addr = 64'h8000_0204;
    tick();
    r_flush = 1'b0;
    run_from_req(64'h8000_0204, 0, 0, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0, 0, "fl_idle");

    // Asynchronous reset mid-WAIT; a late rvalid afterwards is ignored.
    r_cur_addr = 64'h8000_0030;
    tick();
    r_gnt = 1'b1;
    tick();
    r_gnt = 1'b0;
    check("arst_pre_rready", 64'(w_rready), 64'd1);
    #3;
    rst = 1'b0;
    #1;
    check("arst_rready", 64'(w_rready), 64'd0);
    check("arst_inst_addr", w_inst_addr, 64'd0);
    check("arst_req", 64'(w_rd_req), 64'd0);
    tick();
    tick();
    rst        = 1'b1;
    r_rvalid   = 1'b1;
    r_rdata    = 64'hFFFF_FFFF_FFFF_FFFF;
    r_cur_addr = 64'h8000_0304;
    tick();
    r_rvalid = 1'b0;
    check("arst_late_valid", 64'(w_inst_valid), 64'd0);
    run_from_req(64'h8000_0304, 0, 1, 64'h1357_9BDF_2468_ACE0, 1'b0, 0, "arst_restart");

    // Randomized fetches against the reference model.
    for (int n = 0; n < 40; n++) begin
      pc   = 64'h8000_0000 + 64'($urandom_range(0, 1023)) * 4;
      data = {$urandom, $urandom};
      mode = int'($urandom_range(0, 7));
      if (mode == 0) begin
        flush_wait(pc, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), "rnd_fl");
      end else begin
        if (mode == 1) pc = pc + 64'd2;
        fetch(pc, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), data,
              ($urandom_range(0, 5) == 0), int'($urandom_range(0, 3)), "rnd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_if_fetch
`default_nettype wire
